// File: rtl/alu_core.sv
// alu_core: registered 32-bit integer ALU for the single-cycle datapath.
// The next result is computed combinationally from the operands and the
// {funct3_alu, Type_alu} select, then loaded into `result` on every rising
// edge of clk.
//
// Ports:
//   clk        in  1   system clock, rising edge
//   rst        in  1   synchronous active-high reset, clears result
//   operand1   in  32  first operand (rs1)
//   operand2   in  32  second operand (rs2 or immediate)
//   funct3_alu in  3   operation select
//   Type_alu   in  1   operation variant select
//   result     out 32  registered ALU result
module alu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  funct3_alu,
  input  logic        Type_alu,
  output logic [31:0] result
);

  logic signed [31:0] op1_s;
  logic signed [31:0] op2_s;
  logic        [31:0] quotient;
  logic        [31:0] next_result;
  logic        [3:0]  op_sel;

  assign op1_s  = $signed(operand1);
  assign op2_s  = $signed(operand2);
  assign op_sel = {funct3_alu, Type_alu};

  // Divide-by-zero and the single overflowing quotient are resolved here
  // so the divider never yields an undefined value.
  always_comb begin
    quotient = 32'hFFFF_FFFF;
    if (operand2 == 32'h0000_0000) begin
      quotient = 32'hFFFF_FFFF;
    end else if (operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
      quotient = 32'h8000_0000;
    end else begin
      quotient = $unsigned(op1_s / op2_s);
    end
  end

  always_comb begin
    next_result = 32'h0000_0000;
    case (op_sel)
      4'b000_0: next_result = operand1 + operand2;
      4'b000_1: next_result = operand1 - operand2;
      4'b001_0,
      4'b001_1: next_result = operand1 << operand2[4:0];
      4'b010_0: next_result = {31'd0, (op1_s < op2_s)};
      4'b010_1: next_result = {31'd0, (operand1 < operand2)};
      4'b011_0: next_result = quotient;
      4'b011_1: next_result = operand1 * operand2;
      4'b100_0,
      4'b100_1: next_result = operand1 ^ operand2;
      4'b101_0: next_result = operand1 >> operand2[4:0];
      4'b101_1: next_result = {31'd0, (op1_s >= op2_s)};
      4'b110_0,
      4'b110_1: next_result = operand1 | operand2;
      4'b111_0,
      4'b111_1: next_result = operand1 & operand2;
      default:  next_result = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 32'h0000_0000;
    end else begin
      result <= next_result;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core. Stimulus is applied on the falling edge and the
// expected result is queued at the same time; a monitor checks the queue
// head just after each rising edge.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  funct3_alu;
  logic        Type_alu;
  logic [31:0] result;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_core dut (
    .clk        (clk),
    .rst        (rst),
    .operand1   (operand1),
    .operand2   (operand2),
    .funct3_alu (funct3_alu),
    .Type_alu   (Type_alu),
    .result     (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issue(input logic [2:0] f3, input logic t,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input string nm);
    @(negedge clk);
    rst        = 1'b0;
    funct3_alu = f3;
    Type_alu   = t;
    operand1   = a;
    operand2   = b;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  task automatic reset_cycle(input logic [31:0] a, input logic [31:0] b,
                             input string nm);
    @(negedge clk);
    rst        = 1'b1;
    funct3_alu = 3'b000;
    Type_alu   = 1'b0;
    operand1   = a;
    operand2   = b;
    exp_q.push_back(32'h0000_0000);
    name_q.push_back(nm);
  endtask

  // Monitor: result is valid every cycle; compare against each queued entry.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests_run++;
        if (result !== e) begin
          tests_failed++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, result, e);
        end
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    operand1   = 32'h1234_5678;
    operand2   = 32'h9ABC_DEF0;
    funct3_alu = 3'b011;
    Type_alu   = 1'b1;

    reset_cycle(32'hDEAD_BEEF, 32'h0000_0007, "reset_0");
    reset_cycle(32'hFFFF_FFFF, 32'h0000_0001, "reset_1");
    issue(3'b000, 1'b0, 32'd1, 32'd2, 32'h0000_0003, "add_1_2");

    issue(3'b000, 1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h7FFF_FFFE, "add");
    issue(3'b000, 1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0000, "sub");
    issue(3'b100, 1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0000, "xor");
    issue(3'b110, 1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, "or");
    issue(3'b111, 1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, "and");
    issue(3'b010, 1'b0, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0000, "slt_eq");
    issue(3'b010, 1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0000, "sltu_eq");
    issue(3'b101, 1'b1, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "bge_eq");

    issue(3'b001, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFE, "sll_1");
    issue(3'b101, 1'b0, 32'h3FFF_FFFF, 32'h0000_0003, 32'h07FF_FFFF, "srl_3");
    issue(3'b101, 1'b0, 32'h3FFF_FFFF, 32'h0000_0023, 32'h07FF_FFFF, "srl_23");
    issue(3'b101, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, "srl_31");
    issue(3'b001, 1'b1, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll_t1");

    issue(3'b011, 1'b1, 32'h3FFF_FFFF, 32'h0000_0003, 32'hBFFF_FFFD, "mul");
    issue(3'b011, 1'b0, 32'h3FFF_FFFF, 32'h0000_0003, 32'h1555_5555, "div");
    issue(3'b011, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
    issue(3'b011, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    issue(3'b011, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_by0");
    issue(3'b011, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue(3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg");
    issue(3'b010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_big");
    issue(3'b101, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "bge_neg");

    issue(3'b100, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor_t1");
    issue(3'b110, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or_t1");
    issue(3'b111, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and_t1");
    issue(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add_wrap");
    reset_cycle(32'h0000_000A, 32'h0000_0014, "reset_mid");
    issue(3'b000, 1'b0, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, "add_after_rst");
    issue(3'b000, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");

    // Hold the last operation's inputs and let the queue drain.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
